// File: rtl/vga_sram_arbiter_if.sv
// Bus bundle between the VGA fetcher, CPU data port, SRAM controller and the arbiter.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface vga_sram_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              vga_active;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              vga_grant;
  logic              vga_rvalid;
  logic [DATA_W-1:0] vga_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [3:0]        cpu_sel;
  logic              cpu_grant;
  logic              cpu_done;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_sel;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_busy;

  modport master (
    input  vga_active, vga_req, vga_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel,
    input  mem_rdata, mem_busy,
    output vga_grant, vga_rvalid, vga_rdata,
    output cpu_grant, cpu_done, cpu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel
  );

  modport slave (
    output vga_active, vga_req, vga_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_sel,
    output mem_rdata, mem_busy,
    input  vga_grant, vga_rvalid, vga_rdata,
    input  cpu_grant, cpu_done, cpu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel
  );
endinterface

// File: rtl/vga_sram_arbiter.sv
// Single-port SRAM arbiter: VGA has priority in the visible window, CPU starvation is bounded
// by STARVE_LIMIT consecutive VGA wins. All outputs are registered.
module vga_sram_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  vga_sram_arbiter_if.master bus
);
  localparam int unsigned CntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {StIdle, StVgaXfer, StCpuXfer} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   starve_cnt_q, starve_cnt_d;
  logic              last_cpu_q, last_cpu_d;
  logic              vga_win, cpu_win, xfer_done;

  logic              vga_grant_q, vga_grant_d, vga_rvalid_q, vga_rvalid_d;
  logic              cpu_grant_q, cpu_grant_d, cpu_done_q, cpu_done_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d, cpu_rdata_q, cpu_rdata_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_sel_q, mem_sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
      last_cpu_q   <= 1'b1;
      vga_grant_q  <= 1'b0;
      vga_rvalid_q <= 1'b0;
      vga_rdata_q  <= '0;
      cpu_grant_q  <= 1'b0;
      cpu_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= 4'h0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      last_cpu_q   <= last_cpu_d;
      vga_grant_q  <= vga_grant_d;
      vga_rvalid_q <= vga_rvalid_d;
      vga_rdata_q  <= vga_rdata_d;
      cpu_grant_q  <= cpu_grant_d;
      cpu_done_q   <= cpu_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
    end
  end

  // Arbitration and next state; winners are only meaningful in StIdle.
  always_comb begin
    vga_win = 1'b0;
    cpu_win = 1'b0;
    if (state_q == StIdle) begin
      if (bus.cpu_req && (starve_cnt_q == CntW'(STARVE_LIMIT))) begin
        cpu_win = 1'b1;
      end else if (bus.vga_req && bus.vga_active) begin
        vga_win = 1'b1;
      end else if (bus.vga_req && bus.cpu_req) begin
        vga_win = last_cpu_q;
        cpu_win = ~last_cpu_q;
      end else begin
        vga_win = bus.vga_req;
        cpu_win = bus.cpu_req;
      end
    end
    xfer_done = (state_q != StIdle) && !bus.mem_busy;

    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (vga_win)      state_d = StVgaXfer;
        else if (cpu_win) state_d = StCpuXfer;
      end
      StVgaXfer, StCpuXfer: begin
        if (!bus.mem_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    last_cpu_d = last_cpu_q;
    if (vga_win)      last_cpu_d = 1'b0;
    else if (cpu_win) last_cpu_d = 1'b1;

    starve_cnt_d = starve_cnt_q;
    if (!bus.cpu_req || cpu_win) begin
      starve_cnt_d = '0;
    end else if (vga_win && (starve_cnt_q != CntW'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  always_comb begin
    vga_grant_d  = 1'b0;
    vga_rvalid_d = 1'b0;
    vga_rdata_d  = vga_rdata_q;
    cpu_grant_d  = 1'b0;
    cpu_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    if (vga_win) begin
      vga_grant_d = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.vga_addr;
      mem_wdata_d = '0;
      mem_sel_d   = 4'hF;
    end else if (cpu_win) begin
      cpu_grant_d = 1'b1;
      mem_req_d   = 1'b1;
      mem_we_d    = bus.cpu_we;
      mem_addr_d  = bus.cpu_addr;
      mem_wdata_d = bus.cpu_wdata;
      mem_sel_d   = bus.cpu_sel;
    end
    if (xfer_done) begin
      mem_req_d = 1'b0;
      if (state_q == StVgaXfer) begin
        vga_rvalid_d = 1'b1;
        vga_rdata_d  = bus.mem_rdata;
      end else begin
        cpu_done_d = 1'b1;
        // Writes leave the last read value visible to the CPU.
        if (!mem_we_q) cpu_rdata_d = bus.mem_rdata;
      end
    end
  end

  assign bus.vga_grant  = vga_grant_q;
  assign bus.vga_rvalid = vga_rvalid_q;
  assign bus.vga_rdata  = vga_rdata_q;
  assign bus.cpu_grant  = cpu_grant_q;
  assign bus.cpu_done   = cpu_done_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_sel    = mem_sel_q;
endmodule
